riscv_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV64 core (F/D/E/M/WB) in riscv_top's datapath. Generates per-stage stall and flush, and E-stage operand forwarding selects. Runs the start/done handshake with the multi-cycle multiply/divide unit (MDU) in E. Keeps saturating stall and flush cycle counters for performance debug.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/riscv_fwd_unit.sv | 24 ++
 rtl/riscv_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV64 pipeline hazard controller: FSM states, forwarding
// select encoding and the hard-wired zero register index.
package riscv_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_WAIT = 1'b1
  } hazard_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/riscv_fwd_unit.sv
// E-stage operand forwarding select for one source register; purely combinational,
// M beats WB and x0 is never forwarded.
module riscv_fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] i_rs_addr,
  input  logic [4:0] i_mstage_rdaddr,
  input  logic       i_mstage_regwrite,
  input  logic [4:0] i_wbstage_rdaddr,
  input  logic       i_wbstage_regwrite,
  output fwd_sel_e   o_fwd_sel
);

  always_comb begin
    o_fwd_sel = FWD_RF;
    if (i_mstage_regwrite && (i_mstage_rdaddr != X0) && (i_mstage_rdaddr == i_rs_addr)) begin
      o_fwd_sel = FWD_M;
    end else if (i_wbstage_regwrite && (i_wbstage_rdaddr != X0) &&
                 (i_wbstage_rdaddr == i_rs_addr)) begin
      o_fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// 5-stage pipeline sequencing: stall/flush per stage, E-stage forwarding, MDU
// start/done handshake with timeout abort, saturating stall/flush perf counters.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int MDU_MAX_CYCLES = 64
) (
  input  logic             i_riscv_clk,
  input  logic             i_riscv_rst_n,
  input  logic [4:0]       i_dstage_rs1addr,
  input  logic [4:0]       i_dstage_rs2addr,
  input  logic [4:0]       i_estage_rs1addr,
  input  logic [4:0]       i_estage_rs2addr,
  input  logic [4:0]       i_estage_rdaddr,
  input  logic             i_estage_memread,
  input  logic             i_estage_pcsrc,
  input  logic             i_estage_mdu_op,
  input  logic             i_mdu_done,
  input  logic [4:0]       i_mstage_rdaddr,
  input  logic             i_mstage_regwrite,
  input  logic [4:0]       i_wbstage_rdaddr,
  input  logic             i_wbstage_regwrite,
  output logic             o_stall_fstage,
  output logic             o_stall_dstage,
  output logic             o_stall_estage,
  output logic             o_flush_dstage,
  output logic             o_flush_estage,
  output logic             o_flush_mstage,
  output logic [1:0]       o_fwda_sel,
  output logic [1:0]       o_fwdb_sel,
  output logic             o_mdu_start,
  output logic             o_mdu_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WAIT_W = (MDU_MAX_CYCLES > 2) ? $clog2(MDU_MAX_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_MAX_CYCLES - 1);

  hazard_state_e     state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_clr, wait_inc, timeout_set;
  logic              stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start;
  logic              load_use;
  fwd_sel_e          fwda, fwdb;

  riscv_fwd_unit u_fwd_a (
    .i_rs_addr          (i_estage_rs1addr),
    .i_mstage_rdaddr    (i_mstage_rdaddr),
    .i_mstage_regwrite  (i_mstage_regwrite),
    .i_wbstage_rdaddr   (i_wbstage_rdaddr),
    .i_wbstage_regwrite (i_wbstage_regwrite),
    .o_fwd_sel          (fwda)
  );

  riscv_fwd_unit u_fwd_b (
    .i_rs_addr          (i_estage_rs2addr),
    .i_mstage_rdaddr    (i_mstage_rdaddr),
    .i_mstage_regwrite  (i_mstage_regwrite),
    .i_wbstage_rdaddr   (i_wbstage_rdaddr),
    .i_wbstage_regwrite (i_wbstage_regwrite),
    .o_fwd_sel          (fwdb)
  );

  assign load_use = i_estage_memread && (i_estage_rdaddr != X0) &&
                    ((i_estage_rdaddr == i_dstage_rs1addr) ||
                     (i_estage_rdaddr == i_dstage_rs2addr));

  always_comb begin
    state_nxt   = state;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    timeout_set = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    start       = 1'b0;
    case (state)
      IDLE: begin
        if (i_estage_pcsrc) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (i_estage_mdu_op) begin
          start     = 1'b1;
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          flush_m   = 1'b1;
          wait_clr  = 1'b1;
          state_nxt = MDU_WAIT;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MDU_WAIT: begin
        // Done releases the pipe in the same cycle so the result lands in M.
        if (i_mdu_done) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_set = 1'b1;
          flush_e     = 1'b1;
          state_nxt   = IDLE;
        end else begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          wait_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_stall_fstage = i_riscv_rst_n & stall_f;
  assign o_stall_dstage = i_riscv_rst_n & stall_d;
  assign o_stall_estage = i_riscv_rst_n & stall_e;
  assign o_flush_dstage = i_riscv_rst_n & flush_d;
  assign o_flush_estage = i_riscv_rst_n & flush_e;
  assign o_flush_mstage = i_riscv_rst_n & flush_m;
  assign o_mdu_start    = i_riscv_rst_n & start;
  assign o_fwda_sel     = i_riscv_rst_n ? fwda : FWD_RF;
  assign o_fwdb_sel     = i_riscv_rst_n ? fwdb : FWD_RF;

  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
    if (!i_riscv_rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_mdu_timeout <= 1'b0;
      o_stall_cnt   <= '0;
      o_flush_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_set) begin
        o_mdu_timeout <= 1'b1;
      end
      if (o_stall_fstage && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end
      if (o_flush_dstage && (o_flush_cnt != '1)) begin
        o_flush_cnt <= o_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench for riscv_hazard_ctrl: per-cycle expected outputs are queued
// as stimulus is driven and compared when the outputs are sampled.
module tb_riscv_hazard_ctrl;

  localparam int CNT_W = 5;
  localparam int MAXC  = 8;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_MDU  = 6'b111001;
  localparam logic [5:0] C_TO   = 6'b000010;

  typedef struct packed {
    logic [5:0] ctl;
    logic       start;
    logic       to;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct packed {
    logic [4:0] drs1, drs2, ers1, ers2, erd, mrd, wbrd;
    logic       memread, pcsrc, mdu, done, mregw, wbregw;
  } stim_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       drs1, drs2, ers1, ers2, erd, mrd, wbrd;
  logic             memread, pcsrc, mdu, done, mregw, wbregw;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [1:0]       fwda, fwdb;
  logic             mdu_start, mdu_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  riscv_hazard_ctrl #(.CNT_W(CNT_W), .MDU_MAX_CYCLES(MAXC)) dut (
    .i_riscv_clk        (clk),
    .i_riscv_rst_n      (rst_n),
    .i_dstage_rs1addr   (drs1),
    .i_dstage_rs2addr   (drs2),
    .i_estage_rs1addr   (ers1),
    .i_estage_rs2addr   (ers2),
    .i_estage_rdaddr    (erd),
    .i_estage_memread   (memread),
    .i_estage_pcsrc     (pcsrc),
    .i_estage_mdu_op    (mdu),
    .i_mdu_done         (done),
    .i_mstage_rdaddr    (mrd),
    .i_mstage_regwrite  (mregw),
    .i_wbstage_rdaddr   (wbrd),
    .i_wbstage_regwrite (wbregw),
    .o_stall_fstage     (stall_f),
    .o_stall_dstage     (stall_d),
    .o_stall_estage     (stall_e),
    .o_flush_dstage     (flush_d),
    .o_flush_estage     (flush_e),
    .o_flush_mstage     (flush_m),
    .o_fwda_sel         (fwda),
    .o_fwdb_sel         (fwdb),
    .o_mdu_start        (mdu_start),
    .o_mdu_timeout      (mdu_timeout),
    .o_stall_cnt        (stall_cnt),
    .o_flush_cnt        (flush_cnt)
  );

  function automatic exp_t mk(logic [5:0] ctl, logic st, logic to, logic [1:0] fa, logic [1:0] fb);
    exp_t e;
    e.ctl = ctl; e.start = st; e.to = to; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ctl   = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
    o.start = mdu_start;
    o.to    = mdu_timeout;
    o.fa    = fwda;
    o.fb    = fwdb;
    return o;
  endfunction

  function automatic stim_t lu_s(logic mr, logic [4:0] rd, logic [4:0] d1, logic [4:0] d2);
    stim_t t = '0;
    t.memread = mr; t.erd = rd; t.drs1 = d1; t.drs2 = d2;
    return t;
  endfunction

  function automatic stim_t fw_s(logic [4:0] e1, logic [4:0] e2, logic [4:0] m, logic mw,
                                 logic [4:0] w, logic ww);
    stim_t t = '0;
    t.ers1 = e1; t.ers2 = e2; t.mrd = m; t.mregw = mw; t.wbrd = w; t.wbregw = ww;
    return t;
  endfunction

  function automatic stim_t ct_s(logic pc, logic op, logic dn);
    stim_t t = '0;
    t.pcsrc = pc; t.mdu = op; t.done = dn;
    return t;
  endfunction

  task automatic drive(input stim_t t, input exp_t e);
    drs1 = t.drs1; drs2 = t.drs2; ers1 = t.ers1; ers2 = t.ers2; erd = t.erd;
    mrd = t.mrd; wbrd = t.wbrd; memread = t.memread; pcsrc = t.pcsrc;
    mdu = t.mdu; done = t.done; mregw = t.mregw; wbregw = t.wbregw;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t got;
    drive(stim_t'(lu_s(1'b1, 5'd7, 5'd7, 5'd0) | ct_s(1'b1, 1'b1, 1'b0) |
                  fw_s(5'd8, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1)), mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    #12;
    got = observe();
    n_checks++;
    if (got !== sb.pop_front()) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 000", got);
    end
    n_checks++;
    if (stall_cnt !== 5'd0 || flush_cnt !== 5'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    drive('0, mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    void'(sb.pop_front());
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(lu_s(1'b1, 5'd7, 5'd7, 5'd9));  x.push_back(mk(C_LU,   1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back('0);                            x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(lu_s(1'b1, 5'd0, 5'd0, 5'd0));  x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(lu_s(1'b1, 5'd5, 5'd1, 5'd5));  x.push_back(mk(C_LU,   1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(lu_s(1'b1, 5'd5, 5'd6, 5'd7));  x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(lu_s(1'b0, 5'd5, 5'd5, 5'd5));  x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL load_use c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
      if (i == 0) begin
        n_checks++;
        if (stall_cnt !== 5'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d required 1", stall_cnt); end
      end
    end
    n_checks++;
    if (stall_cnt !== 5'd2 || flush_cnt !== 5'd0) begin
      n_fail++; $display("FAIL load_use_totals: got %0d/%0d required 2/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_forwarding();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(fw_s(5'd8,  5'd0, 5'd8,  1'b1, 5'd8,  1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b10, 2'b00));
    s.push_back(fw_s(5'd8,  5'd0, 5'd8,  1'b0, 5'd8,  1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b01, 2'b00));
    s.push_back(fw_s(5'd0,  5'd0, 5'd0,  1'b1, 5'd0,  1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(fw_s(5'd4,  5'd3, 5'd4,  1'b1, 5'd3,  1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b10, 2'b01));
    s.push_back(fw_s(5'd9,  5'd9, 5'd9,  1'b1, 5'd9,  1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b10, 2'b10));
    s.push_back(fw_s(5'd12, 5'd14, 5'd13, 1'b1, 5'd14, 1'b0)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL forwarding c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(stim_t'(ct_s(1'b1, 1'b0, 1'b0) | lu_s(1'b1, 5'd7, 5'd7, 5'd9)));
    x.push_back(mk(C_BR, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b1, 1'b1, 1'b0)); x.push_back(mk(C_BR,   1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back('0);                     x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL branch c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
      if (i == 0) begin
        n_checks++;
        if (flush_cnt !== 5'd1) begin n_fail++; $display("FAIL branch_cnt: got %0d required 1", flush_cnt); end
      end
    end
    n_checks++;
    if (stall_cnt !== 5'd2 || flush_cnt !== 5'd2) begin
      n_fail++; $display("FAIL branch_totals: got %0d/%0d required 2/2", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_back_to_back_mdu();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU, 1'b1, 1'b0, 2'b00, 2'b00));
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) s.push_back(stim_t'(ct_s(1'b1, 1'b1, 1'b0) | lu_s(1'b1, 5'd7, 5'd7, 5'd0)));
      else        s.push_back(ct_s(1'b0, 1'b1, 1'b0));
      x.push_back(mk(C_MDU, 1'b0, 1'b0, 2'b00, 2'b00));
    end
    s.push_back(ct_s(1'b0, 1'b1, 1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU,  1'b1, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU,  1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b0, 1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b1, 1'b0, 1'b0)); x.push_back(mk(C_BR,   1'b0, 1'b0, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL mdu c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cnt !== 5'd9 || flush_cnt !== 5'd3) begin
      n_fail++; $display("FAIL mdu_totals: got %0d/%0d required 9/3", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU, 1'b1, 1'b0, 2'b00, 2'b00));
    for (int k = 1; k < MAXC; k++) begin
      s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU, 1'b0, 1'b0, 2'b00, 2'b00));
    end
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_TO,   1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back('0);                     x.push_back(mk(C_NONE, 1'b0, 1'b1, 2'b00, 2'b00));
    s.push_back(ct_s(1'b1, 1'b0, 1'b0)); x.push_back(mk(C_BR,   1'b0, 1'b1, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL timeout c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cnt !== 5'd17 || flush_cnt !== 5'd4) begin
      n_fail++; $display("FAIL timeout_totals: got %0d/%0d required 17/4", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_async_reset();
    stim_t s[$]; exp_t x[$]; exp_t got, e;
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU, 1'b1, 1'b1, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU, 1'b0, 1'b1, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL arst_pre c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
    pcsrc = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    got = observe(); n_checks++;
    if (got !== mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00)) begin
      n_fail++; $display("FAIL arst_outputs: got %h required 000", got);
    end
    n_checks++;
    if (stall_cnt !== 5'd0 || flush_cnt !== 5'd0) begin
      n_fail++; $display("FAIL arst_counters: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    s.delete(); x.delete();
    s.push_back('0);                     x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b0)); x.push_back(mk(C_MDU,  1'b1, 1'b0, 2'b00, 2'b00));
    s.push_back(ct_s(1'b0, 1'b1, 1'b1)); x.push_back(mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (s[i]) begin
      drive(s[i], x[i]);
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL arst_post c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cnt !== 5'd1) begin n_fail++; $display("FAIL arst_recount: got %0d required 1", stall_cnt); end
  endtask

  task automatic test_saturation();
    exp_t got, e;
    for (int i = 0; i < 70; i++) begin
      if (i < 35) drive(lu_s(1'b1, 5'd3, 5'd3, 5'd0), mk(C_LU, 1'b0, 1'b0, 2'b00, 2'b00));
      else        drive(ct_s(1'b1, 1'b0, 1'b0),       mk(C_BR, 1'b0, 1'b0, 2'b00, 2'b00));
      @(negedge clk);
      got = observe(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL saturate c%0d: got %h required %h", i, got, e); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cnt !== 5'd31 || flush_cnt !== 5'd31) begin
      n_fail++; $display("FAIL saturate_cnt: got %0d/%0d required 31/31", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    drive('0, mk(C_NONE, 1'b0, 1'b0, 2'b00, 2'b00));
    void'(sb.pop_front());
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_back_to_back_mdu();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
